// File: rtl/cmd_dispatch_pkg.sv
// Shared definitions for the command dispatcher: FSM encodings, error codes,
// target field geometry and the target-extraction macro.
`ifndef CMD_DISPATCH_PKG_SV
`define CMD_DISPATCH_PKG_SV

// Pulls the 4-bit target index out of a command word whose field starts at lsb.
`define CMD_DISPATCH_TGT(word, lsb) word[(lsb) +: cmd_dispatch_pkg::TGT_W]

package cmd_dispatch_pkg;

  // Width of the target index field inside a command word.
  localparam int TGT_W = 4;

  // Low half-word of the response when the target index is out of range.
  localparam logic [15:0] ERR_BAD_TGT = 16'hBAD0;
  // Low half-word of the response when the target never signals done.
  localparam logic [15:0] ERR_TIMEOUT = 16'hBAD1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_CMD = 3'd1,
    S_EXE    = 3'd2,
    S_HOLD   = 3'd3,
    S_WR_RSP = 3'd4
  } state_t;

endpackage

`endif

// File: rtl/cmd_dispatch_if.sv
// Bus bundle between the dispatcher, its command/response FIFOs and targets.
interface cmd_dispatch_if #(
  parameter int DATA_W = 32,
  parameter int N_TGT  = 4
);
  logic [DATA_W-1:0]       cmd_data;
  logic                    cmd_waitreq;
  logic                    cmd_rdreq;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_wrreq;
  logic                    rsp_waitreq;
  logic [DATA_W-1:0]       tgt_cmd;
  logic [N_TGT-1:0]        tgt_run;
  logic [N_TGT-1:0]        tgt_done;
  logic [N_TGT*DATA_W-1:0] tgt_rsp;

  // Dispatcher side.
  modport master (
    input  cmd_data, cmd_waitreq, rsp_waitreq, tgt_done, tgt_rsp,
    output cmd_rdreq, rsp_data, rsp_wrreq, tgt_cmd, tgt_run
  );

  // FIFO / target side.
  modport slave (
    output cmd_data, cmd_waitreq, rsp_waitreq, tgt_done, tgt_rsp,
    input  cmd_rdreq, rsp_data, rsp_wrreq, tgt_cmd, tgt_run
  );
endinterface

// File: rtl/cmd_dispatch_timer.sv
// Execution watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the LIMIT-th enabled cycle is being spent.
module dispatch_timer #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == LAST);
endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: pops one command, runs the addressed target until it
// finishes or times out, then pushes exactly one response word.
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int N_TGT   = 4,
  parameter int TGT_LSB = 28,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst_n,
  cmd_dispatch_if.master bus,
  output logic [15:0]    cmd_cnt,
  output logic [15:0]    err_cnt,
  output logic           busy
);
  localparam logic [TGT_W:0] N_TGT_L = (TGT_W + 1)'(N_TGT);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tgt_cmd_q, tgt_cmd_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                err_q, err_d;
  logic [15:0]         cmd_cnt_q, cmd_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;

  logic [TGT_W-1:0]    tgt;
  logic                tgt_ok;
  logic [N_TGT-1:0]    tgt_sel;
  logic [DATA_W-1:0]   rsp_slice [N_TGT];
  logic [DATA_W-1:0]   rsp_sel;
  logic [DATA_W-1:0]   err_hdr;
  logic                done_hit;
  logic                tmr_clr, tmr_en, tmr_tc;

  logic                cmd_rdreq_o, rsp_wrreq_o, busy_o;
  logic [N_TGT-1:0]    tgt_run_o;

  assign tgt    = `CMD_DISPATCH_TGT(tgt_cmd_q, TGT_LSB);
  assign tgt_ok = {1'b0, tgt} < N_TGT_L;

  // Per-target decode of the latched command and slicing of the response bus.
  for (genvar gi = 0; gi < N_TGT; gi++) begin : g_tgt
    assign tgt_sel[gi]   = tgt_ok && (tgt == TGT_W'(gi));
    assign rsp_slice[gi] = bus.tgt_rsp[gi*DATA_W +: DATA_W];
  end

  // Only the addressed target's done counts; the rest are ignored.
  assign done_hit = |(tgt_sel & bus.tgt_done);

  // Response word from the addressed target (tgt_sel is one-hot or zero).
  always_comb begin
    rsp_sel = '0;
    for (int t = 0; t < N_TGT; t++) begin
      if (tgt_sel[t]) begin
        rsp_sel = rsp_slice[t];
      end
    end
  end

  // Error responses carry the offending target index in the top nibble.
  always_comb begin
    err_hdr = '0;
    err_hdr[DATA_W-1 -: TGT_W] = tgt;
  end

  // The watchdog restarts on every visit to S_EXE.
  assign tmr_en  = (state_q == S_EXE);
  assign tmr_clr = (state_q != S_EXE);

  dispatch_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; done takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!bus.cmd_waitreq) state_d = S_RD_CMD;
      S_RD_CMD: state_d = S_EXE;
      S_EXE: begin
        if (!tgt_ok || done_hit || tmr_tc) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD:   if (!bus.rsp_waitreq) state_d = S_WR_RSP;
      S_WR_RSP: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    cmd_rdreq_o = 1'b0;
    rsp_wrreq_o = 1'b0;
    tgt_run_o   = '0;
    busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_RD_CMD: cmd_rdreq_o = 1'b1;
      S_EXE:    tgt_run_o   = tgt_sel;
      S_WR_RSP: rsp_wrreq_o = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: command latch, response capture and saturating statistics.
  always_comb begin
    tgt_cmd_d  = tgt_cmd_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    cmd_cnt_d  = cmd_cnt_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      S_RD_CMD: tgt_cmd_d = bus.cmd_data;
      S_EXE: begin
        if (!tgt_ok) begin
          rsp_data_d        = err_hdr;
          rsp_data_d[15:0]  = ERR_BAD_TGT;
          err_d             = 1'b1;
        end else if (done_hit) begin
          rsp_data_d        = rsp_sel;
          err_d             = 1'b0;
        end else if (tmr_tc) begin
          rsp_data_d        = err_hdr;
          rsp_data_d[15:0]  = ERR_TIMEOUT;
          err_d             = 1'b1;
        end
      end
      S_WR_RSP: begin
        if (cmd_cnt_q != 16'hFFFF) cmd_cnt_d = cmd_cnt_q + 16'd1;
        if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_cmd_q  <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      cmd_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      tgt_cmd_q  <= tgt_cmd_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      cmd_cnt_q  <= cmd_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.cmd_rdreq = cmd_rdreq_o;
  assign bus.rsp_wrreq = rsp_wrreq_o;
  assign bus.tgt_run   = tgt_run_o;
  assign bus.tgt_cmd   = tgt_cmd_q;
  assign bus.rsp_data  = rsp_data_q;
  assign cmd_cnt       = cmd_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign busy          = busy_o;
endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: directed and random commands checked
// against a transaction-level model of the dispatcher's response rules.
module tb_cmd_dispatch;
  localparam int DATA_W  = 32;
  localparam int N_TGT   = 4;
  localparam int TGT_LSB = 28;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_cnt, err_cnt;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int exp_cmd_cnt = 0;
  int exp_err_cnt = 0;
  int txn = 0;

  cmd_dispatch_if #(.DATA_W(DATA_W), .N_TGT(N_TGT)) bus ();

  cmd_dispatch #(
    .DATA_W  (DATA_W),
    .N_TGT   (N_TGT),
    .TGT_LSB (TGT_LSB),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cmd_cnt (cmd_cnt),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: what response, error flag and run length a
  // command must produce given when (if ever) its target says done.
  function automatic void model(input logic [31:0] cmd, input int delay, input logic [31:0] rv,
                                output logic [31:0] rsp, output bit is_err, output int exe);
    int t;
    t = int'(cmd[31:28]);
    if (t >= N_TGT) begin
      rsp = {cmd[31:28], 12'h000, 16'hBAD0}; is_err = 1'b1; exe = 1;
    end else if (delay < TIMEOUT) begin
      rsp = rv; is_err = 1'b0; exe = delay + 1;
    end else begin
      rsp = {cmd[31:28], 12'h000, 16'hBAD1}; is_err = 1'b1; exe = TIMEOUT;
    end
  endfunction

  // One command end to end. delay = S_EXE cycles before the addressed target
  // raises done; hold = cycles the rsp FIFO reports full from the start;
  // keep_avail leaves the cmd FIFO non-empty until the response is written.
  task automatic run_cmd(input logic [31:0] cmd, input int delay, input logic [31:0] rv,
                         input int hold, input bit keep_avail);
    logic [31:0]      exp_rsp, got_rsp, got_cmd;
    bit               exp_err, wr_seen, hit, got_busy;
    int               exe, exp_runs, t, cyc, runs, rd_cnt, wr_full, bad_run, lat;
    logic [N_TGT-1:0] exp_onehot, noise;

    model(cmd, delay, rv, exp_rsp, exp_err, exe);
    t          = int'(cmd[31:28]);
    exp_runs   = (t < N_TGT) ? exe : 0;
    exp_onehot = (t < N_TGT) ? (N_TGT'(1) << t) : '0;

    @(negedge clk);
    for (int i = 0; i < N_TGT; i++) bus.tgt_rsp[i*DATA_W +: DATA_W] = $urandom;
    if (t < N_TGT) bus.tgt_rsp[t*DATA_W +: DATA_W] = rv;
    bus.cmd_data    = cmd;
    bus.cmd_waitreq = 1'b0;
    bus.rsp_waitreq = (hold > 0);
    bus.tgt_done    = '0;

    cyc = 0; runs = 0; rd_cnt = 0; wr_full = 0; bad_run = 0; lat = 0;
    wr_seen = 1'b0; got_rsp = '0; got_cmd = '0; got_busy = 1'b0;
    while (!wr_seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.cmd_rdreq) begin
        rd_cnt++;
        if (!keep_avail) bus.cmd_waitreq = 1'b1;
      end
      hit = 1'b0;
      if (bus.tgt_run != '0) begin
        runs++;
        if (bus.tgt_run !== exp_onehot) bad_run++;
        hit = (runs - 1 == delay);
      end
      if (bus.rsp_wrreq) begin
        wr_seen  = 1'b1;
        if (bus.rsp_waitreq) wr_full++;
        got_rsp  = bus.rsp_data;
        got_cmd  = bus.tgt_cmd;
        got_busy = busy;
        lat      = cyc;
        bus.cmd_waitreq = 1'b1;
      end
      noise = N_TGT'($urandom);
      if (t < N_TGT) noise[t] = hit;
      bus.tgt_done    = noise;
      bus.rsp_waitreq = (cyc < hold);
    end

    check("wr_seen", 64'(wr_seen), 64'd1);
    check("rd_once", 64'(rd_cnt), 64'd1);
    check("wr_while_full", 64'(wr_full), 64'd0);
    check("run_onehot", 64'(bad_run), 64'd0);
    check("run_cycles", 64'(runs), 64'(exp_runs));
    check("rsp_data", 64'(got_rsp), 64'(exp_rsp));
    check("tgt_cmd", 64'(got_cmd), 64'(cmd));
    check("busy_wr", 64'(got_busy), 64'd1);
    if (hold == 0) check("latency", 64'(lat), 64'(3 + exe));

    exp_cmd_cnt++;
    if (exp_err) exp_err_cnt++;

    @(negedge clk);
    bus.tgt_done = '0;
    check("wr_one_cycle", 64'(bus.rsp_wrreq), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
    check("cmd_cnt", 64'(cmd_cnt), 64'(exp_cmd_cnt));
    check("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
    txn++;
    $display("txn %0d cmd=%08h delay=%0d hold=%0d rsp=%08h exp=%08h runs=%0d cmd_cnt=%0d err_cnt=%0d",
             txn, cmd, delay, hold, got_rsp, exp_rsp, runs, cmd_cnt, err_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdreq"},   64'(bus.cmd_rdreq), 64'd0);
    check({tag, "_wrreq"},   64'(bus.rsp_wrreq), 64'd0);
    check({tag, "_run"},     64'(bus.tgt_run),   64'd0);
    check({tag, "_busy"},    64'(busy),          64'd0);
    check({tag, "_rsp"},     64'(bus.rsp_data),  64'd0);
    check({tag, "_tgtcmd"},  64'(bus.tgt_cmd),   64'd0);
    check({tag, "_cmdcnt"},  64'(cmd_cnt),       64'd0);
    check({tag, "_errcnt"},  64'(err_cnt),       64'd0);
  endtask

  initial begin
    int          r, tg, wr_during;
    bit          seen;
    logic [31:0] cmd;

    bus.cmd_data    = '0;
    bus.cmd_waitreq = 1'b1;
    bus.rsp_waitreq = 1'b0;
    bus.tgt_done    = '0;
    bus.tgt_rsp     = '0;

    // Power-on reset.
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed commands.
    run_cmd(32'h1000_0005, 3,    32'h1234_5678, 0,  1'b0);
    run_cmd(32'h7000_0000, 0,    $urandom,      0,  1'b0);
    run_cmd(32'h2000_0000, 1000, $urandom,      0,  1'b0);
    run_cmd(32'h3000_00AA, TIMEOUT - 1, 32'hCAFE_F00D, 0, 1'b0);
    run_cmd(32'h0000_0001, TIMEOUT, 32'h0BAD_BEEF, 0, 1'b0);
    run_cmd(32'h0000_0011, 0,    32'h5555_AAAA, 25, 1'b1);
    run_cmd(32'hF000_0000, 0,    $urandom,      0,  1'b0);
    run_cmd(32'h4123_4567, 2,    $urandom,      3,  1'b0);

    // Random commands, mostly to valid targets.
    for (int n = 0; n < 30; n++) begin
      r   = $urandom_range(0, 9);
      tg  = (r < 8) ? (r % N_TGT) : $urandom_range(N_TGT, 15);
      cmd = {4'(tg), 28'($urandom)};
      run_cmd(cmd, $urandom_range(0, TIMEOUT + 2), $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset while a command is executing.
    @(negedge clk);
    bus.cmd_data    = 32'h1000_0000;
    bus.cmd_waitreq = 1'b0;
    bus.tgt_done    = '0;
    bus.rsp_waitreq = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.cmd_rdreq) bus.cmd_waitreq = 1'b1;
      if (bus.tgt_run != '0) seen = 1'b1;
    end
    check("rst_reach_exe", 64'(seen), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_cmd_cnt = 0;
    exp_err_cnt = 0;
    wr_during = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_wrreq) wr_during++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_wrreq) wr_during++;
    end
    check("rst_no_wr", 64'(wr_during), 64'd0);
    run_cmd(32'h1000_0005, 3, 32'h1234_5678, 0, 1'b0);
    run_cmd(32'h7000_0000, 0, $urandom,      0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 SHALL have parameter DATA_W, default 32: command/response word width.
REQ-002 SHALL have parameter N_TGT, default 4: number of command targets (1..16).
REQ-003 SHALL have parameter TGT_LSB, default 28: LSB of the 4-bit target field in the command word; DATA_W >= TGT_LSB+4 and DATA_W >= 20.
REQ-004 SHALL have parameter TIMEOUT, default 1023: maximum cycles to wait for target done (1..65535).
REQ-005 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_data, input, DATA_W: cmd FIFO read data, valid during the cmd_rdreq cycle.
REQ-008 SHALL have port cmd_waitreq, input, 1: high means cmd FIFO empty.
REQ-009 SHALL have port cmd_rdreq, output, 1: cmd FIFO read strobe.
REQ-010 SHALL have port rsp_data, output, DATA_W: response word, registered.
REQ-011 SHALL have port rsp_wrreq, output, 1: rsp FIFO write strobe.
REQ-012 SHALL have port rsp_waitreq, input, 1: high means rsp FIFO full.
REQ-013 SHALL have port tgt_cmd, output, DATA_W: latched command, broadcast to all targets.
REQ-014 SHALL have port tgt_run, output, N_TGT: one-hot run to the addressed target.
REQ-015 SHALL have port tgt_done, input, N_TGT: per-target completion.
REQ-016 SHALL have port tgt_rsp, input, N_TGT*DATA_W: per-target response, slice t = bits [t*DATA_W +: DATA_W].
REQ-017 SHALL have port cmd_cnt, output, 16: completed-command count, saturating at 0xFFFF.
REQ-018 SHALL have port err_cnt, output, 16: error-response count, saturating at 0xFFFF.
REQ-019 SHALL have port busy, output, 1: high whenever the FSM is not in S_IDLE.

Function
REQ-020 SHALL implement FSM states S_IDLE, S_RD_CMD, S_EXE, S_HOLD, S_WR_RSP.
REQ-021 S_IDLE SHALL go to S_RD_CMD when cmd_waitreq is low; otherwise it stays.
REQ-022 S_RD_CMD SHALL assert cmd_rdreq for exactly one cycle, latch cmd_data into tgt_cmd, and go to S_EXE.
REQ-023 In S_EXE with target t < N_TGT, tgt_run[t] SHALL be high every cycle; all other tgt_run bits SHALL be 0.
REQ-024 In S_EXE, on tgt_done[t] high, the FSM SHALL capture tgt_rsp slice t into rsp_data and go to S_HOLD; tgt_done of non-addressed targets SHALL be ignored.
REQ-025 A target index >= N_TGT SHALL produce no tgt_run and SHALL load the error word {target, zeros, 16'hBAD0} in the first S_EXE cycle.
REQ-026 A 16-bit timer SHALL clear on S_EXE entry; if done has not been seen after TIMEOUT S_EXE cycles, rsp_data SHALL load {target, zeros, 16'hBAD1}, tgt_run SHALL drop, and the FSM SHALL go to S_HOLD.
REQ-027 If done and timeout occur in the same cycle, done SHALL win.
REQ-028 S_HOLD SHALL go to S_WR_RSP when rsp_waitreq is low; it SHALL wait indefinitely otherwise. Responses are never dropped.
REQ-029 S_WR_RSP SHALL assert rsp_wrreq for exactly one cycle, increment cmd_cnt (and err_cnt on an error word), and go to S_IDLE.
REQ-030 Best-case latency from cmd_waitreq low to rsp_wrreq SHALL be 4 cycles with done on the first S_EXE cycle; one command is in flight at a time.
REQ-031 Illegal FSM encodings SHALL return to S_IDLE.

Reset
REQ-032 On rst_n low, asynchronously: FSM=S_IDLE; rsp_data, tgt_cmd, timer, cmd_cnt, err_cnt = 0; cmd_rdreq, rsp_wrreq, tgt_run, busy = 0.
REQ-033 Reset mid-command SHALL abort the command with no response written; the first command after release SHALL be handled normally.

Structure
REQ-034 The shared defs package SHALL hold the FSM state encodings, the error codes 16'hBAD0/16'hBAD1, the target field width (4), and the target-extraction macro.
REQ-035 The timeout counter SHALL be the single sub-module dispatch_timer (clear, enable, terminal-count output).

Verification
REQ-036 Cmd 0x1000_0005, tgt_done[1] after 3 cycles with rsp 0x1234_5678 -> one rsp_wrreq, rsp_data=0x1234_5678, cmd_cnt=1.
REQ-037 Cmd 0x7000_0000 with N_TGT=4 -> tgt_run stays 0, rsp_data=0x7000_BAD0, err_cnt=1.
REQ-038 Cmd to target 2, never done, TIMEOUT=8 -> tgt_run[2] high for 8 cycles, rsp_data=0x2000_BAD1.
REQ-039 rsp_waitreq held high 20 cycles after done -> no rsp_wrreq and no cmd_rdreq until released, then exactly one write.
REQ-040 rst_n pulsed low during S_EXE -> all outputs 0 immediately, no rsp_wrreq; the next command completes normally.
